// File: rtl/vga_score_renderer.sv
// vga_score_renderer: binary score -> BCD (double dabble), tear-free
// frame-start digit swap, scaled 3x5 glyph overlay with change flash.
module vga_score_renderer #(
  parameter int NUM_DIGITS = 7,
  parameter int SCORE_W = 24,
  parameter int SCORE_X = 4,
  parameter int SCORE_Y = 4,
  parameter int SCALE = 1,
  parameter int COORD_W = 8,
  parameter int FLASH_FRAMES = 8,
  parameter logic [23:0] COLOR_RGB = 24'hFFA020,
  parameter logic [23:0] FLASH_RGB = 24'hFFFFFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SCORE_W-1:0] score_in,
  input  logic               score_valid,
  input  logic               frame_start,
  input  logic               blank_lz,
  input  logic [COORD_W-1:0] vx,
  input  logic [COORD_W-1:0] vy,
  output logic               busy,
  output logic               overlay_on,
  output logic [7:0]         overlay_r,
  output logic [7:0]         overlay_g,
  output logic [7:0]         overlay_b
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(SCORE_W + 1);
  localparam int FW = $clog2(FLASH_FRAMES + 2);
  localparam int STRIDE = 4 * SCALE;
  localparam logic [31:0] BOX_W = 32'(STRIDE * NUM_DIGITS);
  localparam logic [31:0] BOX_H = 32'(5 * SCALE);

  function automatic logic [31:0] pow10(input int n);
    logic [31:0] r;
    r = 32'd1;
    for (int i = 0; i < n; i++) r = r * 32'd10;
    return r;
  endfunction

  localparam logic [31:0] MAX_VAL = pow10(NUM_DIGITS) - 32'd1;

  function automatic logic [SCORE_W-1:0] sat(input logic [SCORE_W-1:0] s);
    if (32'(s) > MAX_VAL) return MAX_VAL[SCORE_W-1:0];
    return s;
  endfunction

  function automatic logic [14:0] font(input logic [3:0] d);
    case (d)
      4'd0: font = 15'b111_101_101_101_111;
      4'd1: font = 15'b010_110_010_010_111;
      4'd2: font = 15'b111_001_111_100_111;
      4'd3: font = 15'b111_001_111_001_111;
      4'd4: font = 15'b101_101_111_001_001;
      4'd5: font = 15'b111_100_111_001_111;
      4'd6: font = 15'b111_100_111_101_111;
      4'd7: font = 15'b111_001_001_001_001;
      4'd8: font = 15'b111_101_111_101_111;
      4'd9: font = 15'b111_101_111_001_111;
      default: font = 15'b0;
    endcase
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_LOAD} state_t;

  state_t state_q, state_d;
  logic [SCORE_W-1:0] bin_q, bin_d, nxt_q, nxt_d;
  logic [BW-1:0] bcd_q, bcd_d, pbcd_q, pbcd_d, disp_q, disp_d, adj;
  logic [CW-1:0] cnt_q, cnt_d;
  logic nval_q, nval_d, pend_q, pend_d;
  logic [FW-1:0] flash_q, flash_d;
  logic on_q, on_d;
  logic [23:0] rgb_q, rgb_d;

  logic [COORD_W-1:0] px, py, base, rem;
  logic in_box, lit, seen;
  logic [3:0] dig, nib, bidx;
  logic [1:0] col;
  logic [2:0] row;
  logic [15:0] glyph;
  logic [NUM_DIGITS-1:0] blank;

  // Conversion FSM, pending/next registers, display swap and flash timer
  always_comb begin
    state_d = state_q;
    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    nxt_d = nxt_q;
    nval_d = nval_q;
    pend_d = pend_q;
    pbcd_d = pbcd_q;
    disp_d = disp_q;
    flash_d = flash_q;
    adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;

    if (frame_start) begin
      if (pend_q) begin
        disp_d = pbcd_q;
        pend_d = 1'b0;
      end
      if (pend_q && pbcd_q != disp_q) flash_d = FW'(FLASH_FRAMES);
      else if (flash_q != '0) flash_d = flash_q - 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (score_valid) begin
          bin_d = sat(score_in);
          bcd_d = '0;
          cnt_d = '0;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        bcd_d = {adj[BW-2:0], bin_q[SCORE_W-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(SCORE_W - 1)) state_d = S_LOAD;
      end
      S_LOAD: begin
        pbcd_d = bcd_q;
        pend_d = 1'b1;
        if (nval_q) begin
          bin_d = nxt_q;
          bcd_d = '0;
          cnt_d = '0;
          nval_d = 1'b0;
          state_d = S_CONV;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (score_valid && state_q != S_IDLE) begin
      nxt_d = sat(score_in);
      nval_d = 1'b1;
    end
  end

  // Pixel decode: box test, digit/col/row by constant compares, glyph lookup
  always_comb begin
    px = vx - COORD_W'(SCORE_X);
    py = vy - COORD_W'(SCORE_Y);
    in_box = (vx >= COORD_W'(SCORE_X)) && (vy >= COORD_W'(SCORE_Y)) &&
             (32'(px) < BOX_W) && (32'(py) < BOX_H);
    dig = '0;
    base = '0;
    for (int i = 1; i < NUM_DIGITS; i++)
      if (32'(px) >= 32'(i * STRIDE)) begin
        dig = 4'(i);
        base = COORD_W'(i * STRIDE);
      end
    rem = px - base;
    col = '0;
    for (int c = 1; c < 4; c++)
      if (32'(rem) >= 32'(c * SCALE)) col = 2'(c);
    row = '0;
    for (int r = 1; r < 5; r++)
      if (32'(py) >= 32'(r * SCALE)) row = 3'(r);
    seen = 1'b0;
    blank = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      blank[i] = blank_lz && !seen && (disp_q[4*(NUM_DIGITS-1-i) +: 4] == 4'd0) &&
                 (i != NUM_DIGITS - 1);
      seen = seen || (disp_q[4*(NUM_DIGITS-1-i) +: 4] != 4'd0);
    end
    nib = '0;
    lit = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (dig == 4'(i)) nib = disp_q[4*(NUM_DIGITS-1-i) +: 4];
    glyph = {1'b0, font(nib)};
    bidx = 4'd14 - (4'(row) * 4'd3 + 4'(col));
    lit = in_box && (col != 2'd3) && !blank[dig[$clog2(NUM_DIGITS+1)-1:0] % NUM_DIGITS] &&
          glyph[bidx];
    on_d = lit;
    rgb_d = lit ? ((flash_q != '0) ? FLASH_RGB : COLOR_RGB) : 24'h0;
  end

  // State and pipeline registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      nxt_q <= '0;
      nval_q <= 1'b0;
      pend_q <= 1'b0;
      pbcd_q <= '0;
      disp_q <= '0;
      flash_q <= '0;
      on_q <= 1'b0;
      rgb_q <= '0;
    end else begin
      state_q <= state_d;
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      nxt_q <= nxt_d;
      nval_q <= nval_d;
      pend_q <= pend_d;
      pbcd_q <= pbcd_d;
      disp_q <= disp_d;
      flash_q <= flash_d;
      on_q <= on_d;
      rgb_q <= rgb_d;
    end
  end

  assign busy = (state_q != S_IDLE) | pend_q | nval_q;
  assign overlay_on = on_q;
  assign overlay_r = rgb_q[23:16];
  assign overlay_g = rgb_q[15:8];
  assign overlay_b = rgb_q[7:0];

endmodule
